mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Sequential signed multiply/divide responder for the multicycle MIPS datapath.
- The control unit initiates MULT/DIV with a one-cycle start strobe and waits for `done`. On `done` it leaves its MULT/DIV state, or enters `zerodiv` when `div_zero` is set.
- Holds the architectural HI/LO registers read by MFHI/MFLO.
- Operands come from the A/B register outputs.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- ITER, WIDTH, iteration cycles per operation (one bit per cycle).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset (reset==0 on a rising clk edge resets the block)
- start_mult  input  1  one-cycle strobe: begin signed A*B
- start_div  input  1  one-cycle strobe: begin signed A/B
- a  input  WIDTH  operand A (rs): multiplicand or dividend
- b  input  WIDTH  operand B (rt): multiplier or divisor
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the operation completes
- div_zero  output  1  pulses together with done when a divide had b==0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; internal accumulators cleared. This applies mid-operation too: the operation is abandoned and HI/LO are cleared.
- States: IDLE, MUL_RUN, DIV_RUN, FINISH.
- IDLE:
  - start_mult at edge T: latch a, b; counter=0; go to MUL_RUN.
  - start_div at edge T with b!=0: latch |a|, |b| and the sign flags; go to DIV_RUN.
  - start_div at edge T with b==0: go to FINISH with the dz flag set.
  - start_mult and start_div together: mult wins and start_div is ignored.
- Starts received in any state other than IDLE are ignored. There is no queueing.
- MUL_RUN: radix-2 Booth.
  - 2*WIDTH+1-bit product register {P_hi, P_lo, q-1}.
  - Each cycle: add or subtract the multiplicand into P_hi per {P_lo[0], q-1}, then arithmetic shift right by 1.
  - After ITER cycles go to FINISH.
- DIV_RUN: restoring division on magnitudes.
  - Each cycle: shift {rem, quo} left by 1, trial-subtract |b|, keep the result if non-negative and set the quotient bit.
  - After ITER cycles go to FINISH.
- FINISH (one cycle), then IDLE:
  - Mult: {hi, lo} = 64-bit signed product.
  - Div: lo = quotient truncated toward zero, negated if the operand signs differ. hi = remainder with the sign of the dividend.
  - Div-by-zero: hi/lo unchanged, div_zero=1.
  - In every case done=1 for exactly this cycle.
- Latency (start sampled at edge T):
  - busy=1 from T+1 through the cycle done is high.
  - Mult/div: done high during cycle T+ITER+1 (T+33 at default); hi/lo valid from that same cycle.
  - Div-by-zero: done and div_zero high at T+1.
- Edge cases:
  - 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 with no flag. Only the low WIDTH bits of the quotient are kept.
  - A new start may be accepted in the cycle after done, which is IDLE.
- Arithmetic uses WIDTH+1-bit trial subtraction so there is no overflow in the datapath.
- hi/lo change only in FINISH or on reset.

Optional Feature:
- Macro MDU_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit).
  - abort=1 in MUL_RUN/DIV_RUN returns to IDLE next edge, with busy=0 and no done. hi/lo are unchanged.
  - abort in IDLE or FINISH has no effect.
  - Lets the control unit cancel on exception entry.
- Undefined: no `abort` port; operations always run to completion.

Test Plan:
1. Reset low 2 cycles, release; start_mult a=7, b=0xFFFFFFFD -> busy next cycle; done at T+33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
2. start_mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000 at T+33.
3. start_div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at T+33. Then a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
4. With hi=0x11, lo=0x22, start_div a=5, b=0 -> done=1 and div_zero=1 at T+1; hi=0x11, lo=0x22; busy low at T+2.
5. start_mult 3*4; at T+5 pulse start_div and assert start_mult+start_div -> ignored; done only once at T+33 with lo=12, hi=0.
6. start_div 100/7, drive reset=0 at T+10 -> next cycle busy=0, hi=lo=0, no done. Release and start_div 100/7 -> lo=14, hi=2 at T'+33. With MDU_ABORT_EN, abort at T+10 -> busy=0 at T+11, no done, hi/lo unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit with architectural HI/LO registers.
// Optional abort input enabled by defining MDU_ABORT_EN.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MDU_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DIV_RUN,
    FINISH
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]    cnt;
  logic             last;
  logic             abort_req;
  logic             dz;

  // Booth product register {p_hi, p_lo, p_q}; p_hi carries one guard bit
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   p_hi;
  logic [WIDTH-1:0] p_lo;
  logic             p_q;

  // Restoring divider on magnitudes
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH:0]   mcand_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_hi;
  logic [WIDTH-1:0] booth_lo;

  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_keep;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

`ifdef MDU_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign last = (cnt == CW'(ITER - 1));

  // NOTE: synchronous reset lives inside the clocked block; all state uses <=.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start_mult)     next_state = MUL_RUN;
        else if (start_div) next_state = (b == '0) ? FINISH : DIV_RUN;
      end
      MUL_RUN, DIV_RUN: begin
        if (abort_req) next_state = IDLE;
        else if (last) next_state = FINISH;
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);
  assign div_zero = done & dz;

  // One Booth step: add/subtract per {p_lo[0], p_q}, then arithmetic shift right
  assign mcand_ext = {mcand[WIDTH-1], mcand};

  always_comb begin
    booth_sum = p_hi;
    unique case ({p_lo[0], p_q})
      2'b01:   booth_sum = p_hi + mcand_ext;
      2'b10:   booth_sum = p_hi - mcand_ext;
      default: booth_sum = p_hi;
    endcase
  end

  assign booth_hi = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign booth_lo = {booth_sum[0], p_lo[WIDTH-1:1]};

  // One restoring step; the sign of the WIDTH+1-bit difference is the borrow
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, dvs};
  assign div_keep  = ~div_diff[WIDTH];
  assign rem_next  = div_keep ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_next  = {quo[WIDTH-2:0], div_keep};

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      dz    <= 1'b0;
      mcand <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      p_q   <= 1'b0;
      dvs   <= '0;
      rem   <= '0;
      quo   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_mult) begin
            mcand <= a;
            p_hi  <= '0;
            p_lo  <= b;
            p_q   <= 1'b0;
            cnt   <= '0;
            dz    <= 1'b0;
          end else if (start_div) begin
            dz    <= (b == '0);
            dvs   <= b[WIDTH-1] ? -b : b;
            quo   <= a[WIDTH-1] ? -a : a;
            rem   <= '0;
            q_neg <= a[WIDTH-1] ^ b[WIDTH-1];
            r_neg <= a[WIDTH-1];
            cnt   <= '0;
          end
        end
        MUL_RUN: begin
          if (!abort_req) begin
            p_hi <= booth_hi;
            p_lo <= booth_lo;
            p_q  <= p_lo[0];
            cnt  <= cnt + CW'(1);
            if (last) begin
              hi <= booth_hi[WIDTH-1:0];
              lo <= booth_lo;
            end
          end
        end
        DIV_RUN: begin
          if (!abort_req) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + CW'(1);
            if (last) begin
              lo <= q_neg ? -quo_next : quo_next;
              hi <= r_neg ? -rem_next : rem_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, scoreboard, and
// hand-written sequences for ignored starts, mid-operation reset and abort.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_mult;
  logic         start_div;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef MDU_ABORT_EN
  logic         abort;
`endif
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mult_div_unit #(.WIDTH(W), .ITER(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
`ifdef MDU_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  typedef enum {OP_MUL, OP_DIV} op_e;

  typedef struct {
    op_e          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  vec_t         vecs[14];
  int           n_cmp  = 0;
  int           n_fail = 0;
  logic [W-1:0] m_hi   = '0;
  logic [W-1:0] m_lo   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference arithmetic done in 64-bit signed integers
  function automatic exp_t model(input op_e op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dz  = 1'b0;
    e.lat = W + 1;
    if (op == OP_MUL) begin
      p    = sx * sy;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == '0) begin
      e.dz  = 1'b1;
      e.lat = 1;
      e.hi  = m_hi;
      e.lo  = m_lo;
    end else begin
      q    = sx / sy;
      r    = sx % sy;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  task automatic start_op(input op_e op, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a          = x;
    b          = y;
    start_mult = (op == OP_MUL);
    start_div  = (op == OP_DIV);
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  // Drive one operation, expect its result through the scoreboard
  task automatic run_op(input op_e op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input exp_t e, input string tag);
    int   cyc;
    bit   seen;
    exp_t got;
    sb.push_back(e);
    start_op(op, x, y);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, " busy_after_start"}, busy, 1);
      if (done) seen = 1;
    end
    got = sb.pop_front();
    if (!seen) begin
      check({tag, " done_timeout"}, 0, 1);
    end else begin
      check({tag, " latency"}, cyc, got.lat);
      check({tag, " hi"}, hi, got.hi);
      check({tag, " lo"}, lo, got.lo);
      check({tag, " div_zero"}, div_zero, got.dz);
      @(negedge clk);
      check({tag, " idle_after_done"}, {busy, done}, 2'b00);
    end
    if (!got.dz) begin
      m_hi = got.hi;
      m_lo = got.lo;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   dones;
    int   done_cyc;
    bit   dz_seen;
    logic [W-1:0] cap_hi, cap_lo;

    vecs[0]  = '{OP_MUL, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{OP_MUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[2]  = '{OP_DIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{OP_DIV, 32'd629,      32'd18,       32'h00000011, 32'h00000022, 1'b0};
    vecs[5]  = '{OP_DIV, 32'd5,        32'd0,        32'h00000011, 32'h00000022, 1'b1};
    vecs[6]  = '{OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[7]  = '{OP_DIV, 32'd7,        32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[8]  = '{OP_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[9]  = '{OP_DIV, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
    vecs[10] = '{OP_DIV, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0};
    vecs[11] = '{OP_MUL, 32'd0,        32'h12345678, 32'h00000000, 32'h00000000, 1'b0};
    vecs[12] = '{OP_DIV, 32'd3,        32'h80000000, 32'h00000003, 32'h00000000, 1'b0};
    vecs[13] = '{OP_DIV, 32'h80000000, 32'd0,        32'h00000003, 32'h00000000, 1'b1};

    reset      = 1'b0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a          = '0;
    b          = '0;
`ifdef MDU_ABORT_EN
    abort      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {busy, done, div_zero, hi, lo}, '0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      e.hi  = vecs[i].hi;
      e.lo  = vecs[i].lo;
      e.dz  = vecs[i].dz;
      e.lat = vecs[i].dz ? 1 : W + 1;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, e, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      op_e          op;
      logic [W-1:0] x, y;
      op = ($urandom_range(0, 1) == 1) ? OP_DIV : OP_MUL;
      x  = $urandom;
      y  = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
      run_op(op, x, y, model(op, x, y), $sformatf("rnd%0d", i));
    end

    // Starts while busy, including a simultaneous pair, must be ignored
    start_op(OP_MUL, 32'd3, 32'd4);
    dones    = 0;
    done_cyc = 0;
    dz_seen  = 0;
    cap_hi   = '1;
    cap_lo   = '1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        done_cyc = cyc;
        cap_hi   = hi;
        cap_lo   = lo;
      end
      if (div_zero) dz_seen = 1;
      if (cyc == 5) begin
        a         = 32'd9;
        b         = 32'd0;
        start_div = 1'b1;
      end else if (cyc == 6) begin
        start_mult = 1'b1;
        start_div  = 1'b1;
      end else if (cyc == 7) begin
        start_mult = 1'b0;
        start_div  = 1'b0;
      end
    end
    check("busy_start done_count", dones, 1);
    check("busy_start done_cycle", done_cyc, W + 1);
    check("busy_start hi", cap_hi, 32'd0);
    check("busy_start lo", cap_lo, 32'd12);
    check("busy_start div_zero", dz_seen, 0);

    // Reset in the middle of a divide abandons it and clears HI/LO
    start_op(OP_DIV, 32'd100, 32'd7);
    for (int cyc = 1; cyc <= 9; cyc++) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset busy_done", {busy, done}, 2'b00);
    check("midreset hi_lo", {hi, lo}, 64'd0);
    reset = 1'b1;
    dones = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midreset no_done", dones, 0);
    m_hi = '0;
    m_lo = '0;
    run_op(OP_DIV, 32'd100, 32'd7, model(OP_DIV, 32'd100, 32'd7), "after_reset");
    check("after_reset model_lo", m_lo, 32'd14);

`ifdef MDU_ABORT_EN
    start_op(OP_MUL, 32'd7, 32'hFFFFFFFD);
    for (int cyc = 1; cyc <= 9; cyc++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy_done", {busy, done}, 2'b00);
    dones = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort no_done", dones, 0);
    check("abort hi_lo_kept", {hi, lo}, {32'd2, 32'd14});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
